nibble_serial_add_seq: RTL and testbench
========================================

# nibble_serial_add_seq

Sequencing stage that wraps the team's 4-bit ripple adder to perform NIBBLES×4-bit additions over multiple cycles. It latches wide operands through a valid/ready input handshake and feeds the adder one nibble per cycle, least-significant first. It registers the adder's carry-out back into carry-in and assembles the sum nibbles into a wide result, which it presents through a valid/ready output handshake. The block sits directly upstream and downstream of the adder: it drives A/B/Cin and consumes Sum/Cout.

## Interface
- NIBBLES, 4: operand width in nibbles; W = 4*NIBBLES; legal range 2..16
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands on op_a/op_b/cin_in are valid
- in_ready  out  1  block can accept operands
- op_a  in  W  operand A
- op_b  in  W  operand B
- cin_in  in  1  initial carry-in
- sub  in  1  subtract request; present only with ADDSEQ_SUB_EN
- add_a  out  4  nibble to adder A
- add_b  out  4  nibble to adder B
- add_cin  out  1  carry to adder Cin
- add_sum  in  4  adder Sum (combinational return)
- add_cout  in  1  adder Cout (combinational return)
- out_valid  out  1  result/cout_out valid
- out_ready  in  1  consumer accepts result
- result  out  W  assembled sum
- cout_out  out  1  final carry-out

## Operation
- Reset values: in_ready=1, out_valid=0, result=0, cout_out=0; add_a/add_b/add_cin=0. Internal state=IDLE, idx=0, carry=0.
- The FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch op_a, op_b and carry=cin_in; set idx=0; go to RUN.
- RUN:
  - in_ready=0.
  - Drive add_a=a_reg[4*idx+:4], add_b=b_reg[4*idx+:4], add_cin=carry.
  - Each cycle: result[4*idx+:4]<=add_sum; carry<=add_cout; idx<=idx+1.
  - When idx==NIBBLES-1: cout_out<=add_cout; go to DONE.
- DONE:
  - out_valid=1; result and cout_out are held stable.
  - On out_ready: go to IDLE and clear out_valid.
- Outside RUN, add_a/add_b/add_cin are driven 0.
- idx is $clog2(NIBBLES) bits wide; it is cleared on acceptance and never wraps within an operation.
- Arithmetic is unsigned modulo 2^W. cout_out is the carry out of bit W-1.
- in_ready is low in DONE. A new operand is not accepted in the same cycle the result is consumed.
- in_valid is ignored outside IDLE. Operand inputs may change freely after acceptance.
- Reset asserted mid-operation aborts immediately to the reset values; no partial result is retained.

## Timing
- Accept edge T0, then RUN occupies edges T1..T_NIBBLES (one nibble per edge).
- out_valid rises after edge T_NIBBLES, i.e. latency = NIBBLES+1 cycles from acceptance to out_valid.
- Minimum issue interval is NIBBLES+2 cycles (accept, NIBBLES RUN cycles, one DONE cycle).
- add_* outputs are registered/state-decoded. add_sum/add_cout must settle within one cycle, since the adder is combinational.
- Output handshake completes on any edge where out_valid&out_ready. Backpressure holds DONE indefinitely.

## Configuration
- ADDSEQ_SUB_EN defined:
  - Adds the sub input, sampled at acceptance.
  - When sub=1: b_reg latches ~op_b, initial carry=1, and cin_in is ignored.
  - Result is op_a-op_b mod 2^W; cout_out=1 means no borrow.
- ADDSEQ_SUB_EN undefined: the sub port is absent and the block is add-only.

## Test plan
- NIBBLES=4, 0x1234+0x4321, cin_in=0 -> result=0x5555, cout_out=0; out_valid exactly 5 cycles after acceptance.
- 0xFFFF+0x0001, cin_in=0 -> result=0x0000, cout_out=1; add_cin sequence observed 0,1,1,1.
- 0x8000+0x8000, cin_in=1 -> result=0x0001, cout_out=1.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid: result stays stable and in_ready stays 0.
  - Then out_ready=1 for one cycle -> IDLE; next operands accepted the following cycle.
- Reset mid-op: assert rst_n=0 at RUN idx=2 -> outputs immediately at reset values. After release, 0x0001+0x0001 -> result=0x0002.
- ADDSEQ_SUB_EN, sub=1: 0x0005-0x0007 -> result=0xFFFE, cout_out=0. 0x0007-0x0005 -> result=0x0002, cout_out=1.

Source files
------------

// File: rtl/nibble_serial_add_seq.sv
// nibble_serial_add_seq: sequences a wide add through an external 4-bit ripple adder,
// one nibble per cycle, least-significant nibble first.
// Operands arrive on a valid/ready handshake; the wide result leaves on another.
// Optional feature macro: ADDSEQ_SUB_EN adds a 'sub' input for two's-complement subtraction.
module nibble_serial_add_seq #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   cin_in,
`ifdef ADDSEQ_SUB_EN
  input  logic                   sub,
`endif
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout_out
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IdxW = $clog2(NIBBLES);

  localparam logic [IdxW-1:0] IdxLast = IdxW'(NIBBLES - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    result_q, result_d;
  logic            cout_q, cout_d;

  // Bit offset of the nibble currently being processed.
  logic [IdxW+1:0] bit_ofs;
  assign bit_ofs = {idx_q, 2'b00};

  // Next-state logic: accept operands, step through nibbles, hold result until consumed.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          carry_d = cin_in;
          idx_d   = '0;
          state_d = StRun;
`ifdef ADDSEQ_SUB_EN
          // a - b == a + ~b + 1; cin_in is ignored when subtracting.
          if (sub) begin
            b_d     = ~op_b;
            carry_d = 1'b1;
          end
`endif
        end
      end
      StRun: begin
        result_d[bit_ofs +: 4] = add_sum;
        carry_d                = add_cout;
        if (idx_q == IdxLast) begin
          cout_d  = add_cout;
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  // Outputs are decoded from registered state only; adder inputs are zero outside RUN.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    result    = result_q;
    cout_out  = cout_q;
    add_a     = 4'h0;
    add_b     = 4'h0;
    add_cin   = 1'b0;
    if (state_q == StRun) begin
      add_a   = a_q[bit_ofs +: 4];
      add_b   = b_q[bit_ofs +: 4];
      add_cin = carry_q;
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_seq.sv
// Testbench for nibble_serial_add_seq (NIBBLES=4). A behavioural 4-bit adder closes the loop;
// expected results are queued by the stimulus and checked by an independent monitor.
module tb_nibble_serial_add_seq;
  localparam int unsigned N = 4;
  localparam int unsigned W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         cin_in = 1'b0;
  logic         sub = 1'b0;
  logic [3:0]   add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         cout_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W:0] exp_q[$];

  always #5 clk = ~clk;

  // External combinational 4-bit ripple adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  nibble_serial_add_seq #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin_in    (cin_in),
`ifdef ADDSEQ_SUB_EN
    .sub       (sub),
`endif
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout_out  (cout_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare each consumed result against the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      logic [W:0] e;
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("result", 32'(result), 32'(e[W-1:0]));
        check("cout_out", 32'(cout_out), 32'(e[W]));
      end
    end
  end

  // Issue one operation, check latency and optional add_cin trace, apply backpressure, consume.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input logic sb, input logic [W-1:0] er, input logic ec,
                        input int hold, input logic chk_cin, input logic [3:0] exp_cin);
    int cycles;
    logic [3:0] cin_seq;
    bit got;
    exp_q.push_back({ec, er});
    @(posedge clk); #1;
    op_a = a; op_b = b; cin_in = ci; sub = sb; in_valid = 1'b1;
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    // Scramble inputs after acceptance; the block must have latched them.
    in_valid = 1'b0; op_a = W'($urandom); op_b = W'($urandom); cin_in = ~ci; sub = ~sb;
    cycles = 1; cin_seq = '0; got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) begin got = 1'b1; break; end
      if (k < 4) cin_seq[k] = add_cin;
      check("in_ready_busy", 32'(in_ready), 32'd0);
      @(posedge clk);
      cycles++;
    end
    if (!got) begin
      check("out_valid_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_back());
      return;
    end
    check("latency", 32'(cycles), 32'(N + 1));
    if (chk_cin) check("add_cin_seq", 32'(cin_seq), 32'(exp_cin));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_result", 32'(result), 32'(er));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_cleared", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_add", 32'({add_a, add_b, add_cin}), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 0, 1'b0, 4'h0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 0, 1'b1, 4'b1110);
    run_op(16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1, 0, 1'b1, 4'b0001);
    run_op(16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 10, 1'b0, 4'h0);
    run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 0, 1'b0, 4'h0);

    // Reset while RUN is at idx=2.
    @(posedge clk); #1;
    op_a = 16'h7777; op_b = 16'h1111; cin_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0; #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_cout", 32'(cout_out), 32'd0);
    check("mid_rst_add", 32'({add_a, add_b, add_cin}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 0, 1'b0, 4'h0);

`ifdef ADDSEQ_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 0, 1'b0, 4'h0);
    run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 0, 1'b0, 4'h0);
`endif

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
